// File: rtl/signal_debouncer_pkg.sv
// Shared types for the input debouncer.
// FSM state encoding and a pending-state decode.
package signal_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    PEND_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    PEND_LOW  = 2'd3
  } dbnc_state_e;

  function automatic logic is_pending(
    input dbnc_state_e st
  );
    return (st == PEND_HIGH) ||
           (st == PEND_LOW);
  endfunction

endpackage

// File: rtl/signal_debouncer_synchronizer.sv
// Multi-flop synchronizer for asynchronous
// single-bit inputs, with a settable reset level.
module synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic data_in,
  output logic data_out
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], data_in};
    end
  end

  assign data_out = sync_q[STAGES-1];

endmodule

// File: rtl/signal_debouncer.sv
// Synchronizes and debounces a raw input, reporting
// in-progress qualification and rejected glitches.
module signal_debouncer #(
  parameter int   SYNC_STAGES        = 2,
  parameter int   DEBOUNCE_CYCLES    = 16,
  parameter logic RESET_VALUE        = 1'b0,
  parameter int   GLITCH_COUNT_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          signal,
  input  logic                          glitch_clear,
  output logic                          debounced,
  output logic                          bouncing,
  output logic                          glitch,
  output logic [GLITCH_COUNT_WIDTH-1:0] glitch_count
);

  import signal_debouncer_pkg::*;

  localparam int CW =
    $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_COUNT_WIDTH-1:0] GMAX =
    '1;
  localparam dbnc_state_e RST_ST =
    RESET_VALUE ? ST_HIGH : ST_LOW;

  logic                          s;
  dbnc_state_e                   state_q;
  logic [CW-1:0]                 cnt_q;
  logic [CW-1:0]                 cnt_d;
  logic                          deb_q;
  logic                          glitch_q;
  logic [GLITCH_COUNT_WIDTH-1:0] gcnt_q;
  logic                          reject;

  synchronizer #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .data_in  (signal),
    .data_out (s)
  );

  assign cnt_d  = cnt_q + 1'b1;
  assign reject =
    ((state_q == PEND_HIGH) && !s) ||
    ((state_q == PEND_LOW)  &&  s);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RST_ST;
      cnt_q    <= '0;
      deb_q    <= RESET_VALUE;
      glitch_q <= 1'b0;
      gcnt_q   <= '0;
    end else begin
      glitch_q <= reject;
      unique case (state_q)
        ST_LOW: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= ST_HIGH;
              deb_q   <= 1'b1;
            end else begin
              state_q <= PEND_HIGH;
              cnt_q   <= CW'(1);
            end
          end
        end
        PEND_HIGH: begin
          if (!s) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
            deb_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_HIGH: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= ST_LOW;
              deb_q   <= 1'b0;
            end else begin
              state_q <= PEND_LOW;
              cnt_q   <= CW'(1);
            end
          end
        end
        PEND_LOW: begin
          if (s) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
      endcase
      // clear has priority over a same-cycle glitch
      if (glitch_clear) begin
        gcnt_q <= '0;
      end else if (reject && (gcnt_q != GMAX)) begin
        gcnt_q <= gcnt_q + 1'b1;
      end
    end
  end

  assign debounced    = deb_q;
  assign bouncing     = is_pending(state_q);
  assign glitch       = glitch_q;
  assign glitch_count = gcnt_q;

endmodule

// File: tb/tb_signal_debouncer.sv
// Directed bench for signal_debouncer: three configured
// instances checked against a run-length model each cycle.
module tb_signal_debouncer;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [N];
  logic       sig [N];
  logic       clr [N];
  logic       deb [N];
  logic       bnc [N];
  logic       gl  [N];
  logic [7:0] gc_a;
  logic [1:0] gc_b;
  logic [7:0] gc_c;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // per-instance configuration for the model
  int   m_sync [N] = '{2, 2, 3};
  int   m_deb  [N] = '{4, 4, 1};
  int   m_max  [N] = '{255, 3, 255};
  logic m_rv   [N] = '{1'b0, 1'b0, 1'b1};

  logic [7:0] pipe  [N];
  logic       m_lvl [N];
  int         m_run [N];
  logic       m_gl  [N];
  int         m_cnt [N];

  signal_debouncer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .RESET_VALUE(1'b0), .GLITCH_COUNT_WIDTH(8)
  ) u_a (
    .clock(clk), .reset(rst[0]), .signal(sig[0]),
    .glitch_clear(clr[0]), .debounced(deb[0]),
    .bouncing(bnc[0]), .glitch(gl[0]),
    .glitch_count(gc_a)
  );

  signal_debouncer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .RESET_VALUE(1'b0), .GLITCH_COUNT_WIDTH(2)
  ) u_b (
    .clock(clk), .reset(rst[1]), .signal(sig[1]),
    .glitch_clear(clr[1]), .debounced(deb[1]),
    .bouncing(bnc[1]), .glitch(gl[1]),
    .glitch_count(gc_b)
  );

  signal_debouncer #(
    .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1),
    .RESET_VALUE(1'b1), .GLITCH_COUNT_WIDTH(8)
  ) u_c (
    .clock(clk), .reset(rst[2]), .signal(sig[2]),
    .glitch_clear(clr[2]), .debounced(deb[2]),
    .bouncing(bnc[2]), .glitch(gl[2]),
    .glitch_count(gc_c)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Model: level accepted after DEB consecutive
  // differing samples; a break in the run is a glitch.
  task automatic step(input int i);
    logic x;
    logic g;
    g = 1'b0;
    if (rst[i]) begin
      pipe[i]  = {8{m_rv[i]}};
      m_lvl[i] = m_rv[i];
      m_run[i] = 0;
      m_cnt[i] = 0;
    end else begin
      x = pipe[i][m_sync[i]-1];
      pipe[i] = {pipe[i][6:0], sig[i]};
      if (x != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] >= m_deb[i]) begin
          m_lvl[i] = x;
          m_run[i] = 0;
        end
      end else if (m_run[i] > 0) begin
        g = 1'b1;
        m_run[i] = 0;
      end
      if (clr[i])
        m_cnt[i] = 0;
      else if (g && m_cnt[i] < m_max[i])
        m_cnt[i]++;
    end
    m_gl[i] = g;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) step(i);
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("deb%0d", i),
            32'(deb[i]), 32'(m_lvl[i]));
        chk($sformatf("bnc%0d", i),
            32'(bnc[i]), 32'(m_run[i] > 0));
        chk($sformatf("gl%0d", i),
            32'(gl[i]), 32'(m_gl[i]));
      end
      chk("gc0", 32'(gc_a), m_cnt[0]);
      chk("gc1", 32'(gc_b), m_cnt[1]);
      chk("gc2", 32'(gc_c), m_cnt[2]);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int   rise;
    logic [4:0] tr;
    tr = 5'b10101;
    for (int i = 0; i < N; i++) begin
      rst[i]   = 1'b1;
      clr[i]   = 1'b0;
      sig[i]   = m_rv[i];
      pipe[i]  = '0;
      m_lvl[i] = 1'b0;
      m_run[i] = 0;
      m_gl[i]  = 1'b0;
      m_cnt[i] = 0;
    end
    tick();
    armed = 1'b1;
    tick();
    chk("rst_deb_a", 32'(deb[0]), 0);
    chk("rst_bnc_a", 32'(bnc[0]), 0);
    chk("rst_gl_a",  32'(gl[0]),  0);
    chk("rst_gc_a",  32'(gc_a),   0);
    chk("rst_deb_c", 32'(deb[2]), 1);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;

    // held rise
    sig[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("rise_bnc_e%0d", e),
          32'(bnc[0]), 32'(e >= 3 && e <= 5));
      chk($sformatf("rise_deb_e%0d", e),
          32'(deb[0]), 32'(e >= 6));
      chk($sformatf("rise_gl_e%0d", e),
          32'(gl[0]), 0);
    end
    sig[0] = 1'b0;
    repeat (8) tick();
    chk("fall_deb", 32'(deb[0]), 0);

    // two-cycle pulse is rejected
    sig[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      if (e == 3) sig[0] = 1'b0;
      tick();
      chk($sformatf("pulse_bnc_e%0d", e),
          32'(bnc[0]), 32'(e == 3 || e == 4));
      chk($sformatf("pulse_gl_e%0d", e),
          32'(gl[0]), 32'(e == 5));
      chk($sformatf("pulse_deb_e%0d", e),
          32'(deb[0]), 0);
    end
    chk("pulse_gc", 32'(gc_a), 1);

    // bounce train then steady high
    rise = 0;
    for (int e = 1; e <= 14; e++) begin
      sig[0] = (e <= 5) ? tr[e-1] : 1'b1;
      tick();
      if (deb[0] && rise == 0) rise = e;
    end
    chk("train_rise_edge", rise, 10);
    chk("train_gc", 32'(gc_a), 3);

    // mirror train then steady low
    rise = 0;
    for (int e = 1; e <= 14; e++) begin
      sig[0] = (e <= 5) ? ~tr[e-1] : 1'b0;
      tick();
      if (!deb[0] && rise == 0) rise = e;
    end
    chk("mirror_fall_edge", rise, 10);
    chk("mirror_gc", 32'(gc_a), 5);

    // reset mid-qualification
    sig[0] = 1'b1;
    repeat (4) tick();
    chk("pend_bnc", 32'(bnc[0]), 1);
    rst[0] = 1'b1;
    tick();
    chk("mrst_deb", 32'(deb[0]), 0);
    chk("mrst_bnc", 32'(bnc[0]), 0);
    chk("mrst_gl",  32'(gl[0]),  0);
    chk("mrst_gc",  32'(gc_a),   0);
    rst[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("requal_deb_e%0d", e),
          32'(deb[0]), 32'(e >= 6));
      chk($sformatf("requal_gl_e%0d", e),
          32'(gl[0]), 0);
    end
    sig[0] = 1'b0;
    repeat (8) tick();

    // saturation on the 2-bit counter
    for (int g = 0; g < 5; g++) begin
      sig[1] = 1'b1;
      tick();
      sig[1] = 1'b0;
      repeat (3) tick();
    end
    chk("sat_gc", 32'(gc_b), 3);
    sig[1] = 1'b1;
    tick();
    sig[1] = 1'b0;
    repeat (2) tick();
    clr[1] = 1'b1;
    tick();
    chk("clr_gl", 32'(gl[1]), 1);
    chk("clr_gc", 32'(gc_b), 0);
    clr[1] = 1'b0;
    tick();

    // single-sample bypass, reset-high instance
    for (int e = 1; e <= 7; e++) begin
      sig[2] = (e == 1) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("byp_deb_e%0d", e),
          32'(deb[2]), 32'(e != 4));
      chk($sformatf("byp_bnc_e%0d", e),
          32'(bnc[2]), 0);
    end
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
